// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter.
// Step states and the instruction used when a fetch is force-completed.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_FETCH,
    S_RELEASE
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle watchdog for one memory access.
// Pulses expire on the LIMIT-th consecutive cycle of an access without ready.
module mem_arb_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = active && !ready && (cnt_q == CW'(LIMIT - 1));
    cnt_d  = cnt_q + CW'(1);
    if (!active || ready || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises data then fetch accesses of one pipeline step onto a single memory port.
// Optional access timeout with sticky mem_err: define MEM_ARB_TIMEOUT_EN.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr_f,
  input  logic              dmem_read_m,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] dmem_write_data,
  output logic [DATA_W-1:0] dmem_read_data,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              expire;
  logic              done;

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q, err_d;

  mem_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .active (mem_req),
    .ready  (mem_ready),
    .expire (expire)
  );

  always_comb err_d = err_q | expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expire  = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign done           = mem_ready | expire;
  assign mem_stall      = (state_q != S_RELEASE);
  assign instr_f        = instr_q;
  assign dmem_read_data = rdata_q;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    instr_d   = instr_q;
    rdata_d   = rdata_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        data_d  = '0;
        state_d = (dmem_read_m | dmem_write) ? S_DATA : S_FETCH;
      end
      S_DATA: begin
        mem_req   = 1'b1;
        mem_we    = dmem_write;
        mem_addr  = alu_out;
        mem_wdata = dmem_write_data;
        if (done) begin
          // writes (incl. read+write) and timed-out reads return zero
          data_d  = (dmem_write || !mem_ready) ? '0 : mem_rdata;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (done) begin
          instr_d = mem_ready ? mem_rdata : DATA_W'(NOP_INSTR);
          rdata_d = data_q;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      instr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: vector table of pipeline steps against a
// variable-latency memory responder, plus reset and timeout sequences.
module tb_unified_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] instr_f;
  logic        dmem_read_m = 1'b0;
  logic        dmem_write = 1'b0;
  logic [31:0] alu_out = '0;
  logic [31:0] dmem_write_data = '0;
  logic [31:0] dmem_read_data;
  logic        mem_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr_f(instr_f),
    .dmem_read_m(dmem_read_m), .dmem_write(dmem_write),
    .alu_out(alu_out), .dmem_write_data(dmem_write_data),
    .dmem_read_data(dmem_read_data), .mem_stall(mem_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rdata;
    logic        chk_rd;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc;
    int          waits;
    logic [31:0] e_instr;
    logic [31:0] e_rdata;
    logic        chk_rd;
    int          n_acc;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [bit [31:0]];
  acc_t        log_q[$];
  exp_t        sb_q[$];
  int          waits_g = 0;
  bit          hang = 1'b0;
  int          wcnt = 0;
  int          unstable = 0;
  acc_t        cap;
  bit          after_reset = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    case (a)
      32'h40:  return 32'h2008_0005;
      32'h44:  return 32'h8C09_0100;
      32'h48:  return 32'hAC0A_0104;
      32'h4C:  return 32'h0109_5020;
      32'h100: return 32'h1234_5678;
      default: return 32'hBAD0_0000 ^ a;
    endcase
  endfunction

  // memory model: answers after waits_g wait cycles, never when hang is set
  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        cap = '{mem_we, mem_addr, mem_wdata};
      end else if (mem_we !== cap.we || mem_addr !== cap.addr ||
                   mem_wdata !== cap.wdata) begin
        unstable++;
      end
      if (!hang && wcnt >= waits_g) begin
        mem_ready = 1'b1;
        mem_rdata = rd_mem(mem_addr);
        log_q.push_back(cap);
        if (mem_we) mem[mem_addr] = mem_wdata;
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        wcnt++;
      end
    end
  end

  task automatic do_step(input vec_t v, input string tag);
    exp_t e;
    int   cyc;
    int   lbase;
    int   ubase;
    int   lat;
    bit   seen;
    bit   dacc;
    dmem_read_m     = v.rd;
    dmem_write      = v.wr;
    alu_out         = v.alu;
    dmem_write_data = v.wd;
    pc              = v.pc;
    waits_g         = v.waits;
    lbase = log_q.size();
    ubase = unstable;
    sb_q.push_back('{v.e_instr, v.e_rdata, v.chk_rd});
    cyc = after_reset ? 1 : 0;
    after_reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      seen = !mem_stall;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    if (!seen) return;
    dacc = v.rd | v.wr;
    lat = (v.lat >= 0) ? v.lat :
          (dacc ? 4 + 2 * v.waits : 3 + v.waits);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    e = sb_q.pop_front();
    check({tag, "_instr"}, instr_f, e.instr);
    if (e.chk_rd) check({tag, "_rdata"}, dmem_read_data, e.rdata);
    check({tag, "_naccess"}, 32'(log_q.size() - lbase), 32'(v.n_acc));
    check({tag, "_stable"}, 32'(unstable - ubase), 32'd0);
    if (log_q.size() - lbase == v.n_acc && v.n_acc > 0) begin
      if (dacc) begin
        check({tag, "_d_we"}, 32'(log_q[lbase].we), 32'(v.wr));
        check({tag, "_d_addr"}, log_q[lbase].addr, v.alu);
        if (v.wr) check({tag, "_d_wdata"}, log_q[lbase].wdata, v.wd);
      end
      check({tag, "_f_we"}, 32'(log_q[lbase + v.n_acc - 1].we), 32'd0);
      check({tag, "_f_addr"}, log_q[lbase + v.n_acc - 1].addr, v.pc);
    end
  endtask

  vec_t vecs[6];
  vec_t vpost;
  vec_t vto;
  vec_t vok;

  initial begin
    //           rd    wr    alu     wd            pc     w  instr          rdata         chk   n  lat
    vecs[0] = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h40, 0, 32'h2008_0005, 32'h0,        1'b0, 1, -1};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h44, 2, 32'h8C09_0100, 32'h1234_5678, 1'b1, 2, -1};
    vecs[2] = '{1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 32'h48, 1, 32'hAC0A_0104, 32'h0,        1'b1, 2, -1};
    vecs[3] = '{1'b1, 1'b0, 32'h104, 32'h0,        32'h4C, 0, 32'h0109_5020, 32'hDEADBEEF, 1'b1, 2, -1};
    vecs[4] = '{1'b1, 1'b1, 32'h108, 32'hCAFEF00D, 32'h40, 3, 32'h2008_0005, 32'h0,        1'b1, 2, -1};
    vecs[5] = '{1'b1, 1'b0, 32'h108, 32'h0,        32'h44, 0, 32'h8C09_0100, 32'hCAFEF00D, 1'b1, 2, -1};
    vpost   = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h4C, 0, 32'h0109_5020, 32'h0,        1'b0, 1, -1};
    vto     = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h40, 0, 32'h0,        32'h0,        1'b0, 0, 2 + TO};
    vok     = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h48, 1, 32'hAC0A_0104, 32'h1234_5678, 1'b1, 2, -1};

    repeat (3) @(negedge clk);
    check("rst_stall", 32'(mem_stall), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_instr", instr_f, 32'h0);
    check("rst_rdata", dmem_read_data, 32'h0);
    check("rst_err", 32'(mem_err), 32'd0);
    reset = 1'b0;
    after_reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_step(vecs[i], $sformatf("vec%0d", i));
    end

    // reset while the data access is waiting
    dmem_read_m = 1'b1;
    dmem_write  = 1'b0;
    alu_out     = 32'h100;
    pc          = 32'h44;
    hang        = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_req_before", 32'(mem_req), 32'd1);
    check("mid_addr_before", mem_addr, 32'h100);
    #2 reset = 1'b1;
    #1;
    check("mid_req_after", 32'(mem_req), 32'd0);
    check("mid_stall_after", 32'(mem_stall), 32'd1);
    check("mid_rdata_after", dmem_read_data, 32'h0);
    @(negedge clk);
    hang = 1'b0;
    reset = 1'b0;
    after_reset = 1'b1;
    do_step(vpost, "post_rst");

`ifdef MEM_ARB_TIMEOUT_EN
    hang = 1'b1;
    do_step(vto, "timeout");
    check("timeout_err", 32'(mem_err), 32'd1);
    hang = 1'b0;
    do_step(vok, "after_to");
    check("err_sticky", 32'(mem_err), 32'd1);
`else
    do_step(vok, "final");
    check("err_tied", 32'(mem_err), 32'd0);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
